// File: rtl/load_use_scoreboard.sv
// ID-stage load-use interlock: per-register pending-load counters, stall FSM and stall watchdog.
// Optional SCOREBOARD_PERF_EN adds a free-running stall_cycles counter output.

module load_use_reg_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             done_hit,
    output logic             pend,
    output logic [CNT_W-1:0] eff
);

    logic [CNT_W-1:0] cnt;
    logic             dec;

    assign pend = (cnt != '0);
    assign dec  = done_hit & pend;
    // A load completing at WB this cycle is already forwardable, so it no longer blocks.
    assign eff  = cnt - CNT_W'(dec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc & ~dec)
            cnt <= cnt + CNT_W'(1);
        else if (dec & ~inc)
            cnt <= cnt - CNT_W'(1);
    end

endmodule

module load_use_scoreboard #(
    parameter int CNT_W     = 2,
    parameter int MAX_STALL = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_valid,
    input  logic [4:0]  ds_rf_raddr1,
    input  logic [4:0]  ds_rf_raddr2,
    input  logic        ds_use_r1,
    input  logic        ds_use_r2,
    input  logic        ds_rf_we,
    input  logic [4:0]  ds_rf_waddr,
    input  logic        ds_is_load,
    input  logic        es_allow_in,
    input  logic        ld_done,
    input  logic [4:0]  ld_done_waddr,
    output logic        stall,
    output logic        issue,
    output logic [31:0] pend_mask,
`ifdef SCOREBOARD_PERF_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        in_stall,
    output logic        wdog_err
);

    localparam int SL_W = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
    localparam logic [SL_W-1:0] SL_MAX = SL_W'(MAX_STALL - 1);

    typedef enum logic {RUN, STALL} state_t;

    logic [31:0][CNT_W-1:0] eff_all;
    logic [31:0]            pend_vec;
    logic [31:0]            inc_vec;
    logic [31:0]            hit_vec;
    logic                   hz1, hz2, hzf;
    logic                   ld_alloc;

    state_t                 state;
    logic [SL_W-1:0]        stall_len;

    // r0 is hardwired zero and never tracked.
    assign eff_all[0]  = '0;
    assign pend_vec[0] = 1'b0;
    assign inc_vec[0]  = 1'b0;
    assign hit_vec[0]  = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_reg
            assign inc_vec[gi] = ld_alloc & (ds_rf_waddr == 5'(gi));
            assign hit_vec[gi] = ld_done & (ld_done_waddr == 5'(gi));

            load_use_reg_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .inc      (inc_vec[gi]),
                .done_hit (hit_vec[gi]),
                .pend     (pend_vec[gi]),
                .eff      (eff_all[gi])
            );
        end
    endgenerate

    assign hz1 = ds_use_r1 & (ds_rf_raddr1 != 5'd0) & (eff_all[ds_rf_raddr1] != '0);
    assign hz2 = ds_use_r2 & (ds_rf_raddr2 != 5'd0) & (eff_all[ds_rf_raddr2] != '0);
    // A full counter would overflow on one more load to the same destination.
    assign hzf = ds_is_load & ds_rf_we & (ds_rf_waddr != 5'd0) & (eff_all[ds_rf_waddr] == '1);

    assign stall     = ds_valid & (hz1 | hz2 | hzf);
    assign issue     = ds_valid & ~stall & es_allow_in;
    assign ld_alloc  = issue & ds_is_load & ds_rf_we & (ds_rf_waddr != 5'd0);
    assign pend_mask = pend_vec;

    // stall_len counts consecutive stall cycles already seen, saturating at MAX_STALL-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            in_stall  <= 1'b0;
            stall_len <= '0;
            wdog_err  <= 1'b0;
        end else begin
            if (stall && stall_len == SL_MAX)
                wdog_err <= 1'b1;
            case (state)
                RUN: begin
                    if (stall) begin
                        state     <= STALL;
                        in_stall  <= 1'b1;
                        stall_len <= (stall_len == SL_MAX) ? SL_MAX : stall_len + SL_W'(1);
                    end else begin
                        stall_len <= '0;
                    end
                end
                STALL: begin
                    if (stall) begin
                        stall_len <= (stall_len == SL_MAX) ? SL_MAX : stall_len + SL_W'(1);
                    end else begin
                        state     <= RUN;
                        in_stall  <= 1'b0;
                        stall_len <= '0;
                    end
                end
                default: begin
                    state     <= RUN;
                    in_stall  <= 1'b0;
                    stall_len <= '0;
                end
            endcase
        end
    end

`ifdef SCOREBOARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (stall)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Scoreboard bench for load_use_scoreboard: directed test-plan sequences plus random traffic
// checked against a per-register pending-count model.

module tb_load_use_scoreboard;

    localparam int CNT_W     = 2;
    localparam int MAX_STALL = 16;
    localparam int CMAX      = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst, valid, u1, u2, we, ld, allow, done;
        logic [4:0] ra1, ra2, wa, dwa;
    } stim_t;

    typedef struct packed {
        logic        stall, issue, ins, wd;
        logic [31:0] pm, sc;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_valid = 1'b0, ds_use_r1 = 1'b0, ds_use_r2 = 1'b0, ds_rf_we = 1'b0;
    logic        ds_is_load = 1'b0, es_allow_in = 1'b0, ld_done = 1'b0;
    logic [4:0]  ds_rf_raddr1 = '0, ds_rf_raddr2 = '0, ds_rf_waddr = '0, ld_done_waddr = '0;
    logic        stall, issue, in_stall, wdog_err;
    logic [31:0] pend_mask;
    logic [31:0] stall_cycles_w;

    load_use_scoreboard #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk           (clk),
        .reset         (reset),
        .ds_valid      (ds_valid),
        .ds_rf_raddr1  (ds_rf_raddr1),
        .ds_rf_raddr2  (ds_rf_raddr2),
        .ds_use_r1     (ds_use_r1),
        .ds_use_r2     (ds_use_r2),
        .ds_rf_we      (ds_rf_we),
        .ds_rf_waddr   (ds_rf_waddr),
        .ds_is_load    (ds_is_load),
        .es_allow_in   (es_allow_in),
        .ld_done       (ld_done),
        .ld_done_waddr (ld_done_waddr),
        .stall         (stall),
        .issue         (issue),
        .pend_mask     (pend_mask),
`ifdef SCOREBOARD_PERF_EN
        .stall_cycles  (stall_cycles_w),
`endif
        .in_stall      (in_stall),
        .wdog_err      (wdog_err)
    );

`ifndef SCOREBOARD_PERF_EN
    assign stall_cycles_w = '0;
`endif

    always #5 clk = ~clk;

    // reference model state
    int          m_cnt [32];
    int          m_run;
    bit          m_ins, m_wd;
    bit [31:0]   m_sc;
    stim_t       cur;
    bit          cur_stall, cur_issue;
    int          cyc_n;

    exp_t        q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, c, act, exp);
        end
    endtask

    function automatic int eff(input int i);
        if (cur.done && cur.dwa == 5'(i) && m_cnt[i] > 0) return m_cnt[i] - 1;
        return m_cnt[i];
    endfunction

    task automatic model_clear();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_run = 0; m_ins = 0; m_wd = 0; m_sc = 0;
    endtask

    task automatic model_edge();
        int old [32];
        old = m_cnt;
        if (cur_issue && cur.ld && cur.we && cur.wa != 0) m_cnt[cur.wa]++;
        if (cur.done && cur.dwa != 0 && old[cur.dwa] > 0) m_cnt[cur.dwa]--;
        if (cur_stall) begin
            m_run++;
            m_sc++;
            if (m_run >= MAX_STALL) m_wd = 1;
        end else begin
            m_run = 0;
        end
        m_ins = cur_stall;
    endtask

    task automatic step(input stim_t s);
        exp_t        e;
        bit          hz;
        logic [31:0] pm;
        @(posedge clk);
        #1;
        if (!cur.rst) model_edge();
        reset = s.rst;       ds_valid = s.valid;   ds_use_r1 = s.u1;     ds_use_r2 = s.u2;
        ds_rf_we = s.we;     ds_is_load = s.ld;    es_allow_in = s.allow; ld_done = s.done;
        ds_rf_raddr1 = s.ra1; ds_rf_raddr2 = s.ra2; ds_rf_waddr = s.wa;  ld_done_waddr = s.dwa;
        cur = s;
        if (s.rst) model_clear();
        hz = (s.u1 && s.ra1 != 0 && eff(s.ra1) != 0) ||
             (s.u2 && s.ra2 != 0 && eff(s.ra2) != 0) ||
             (s.ld && s.we && s.wa != 0 && eff(s.wa) == CMAX);
        cur_stall = s.valid && hz;
        cur_issue = s.valid && !cur_stall && s.allow;
        pm = '0;
        for (int i = 1; i < 32; i++) pm[i] = (m_cnt[i] != 0);
        e.stall = cur_stall; e.issue = cur_issue; e.ins = m_ins; e.wd = m_wd;
        e.pm = pm; e.sc = m_sc; e.cyc = cyc_n;
        q.push_back(e);
        cyc_n++;
    endtask

    // monitor: every cycle the DUT presents its outputs; compare against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall",     32'(stall),    32'(e.stall), e.cyc);
                chk("issue",     32'(issue),    32'(e.issue), e.cyc);
                chk("pend_mask", pend_mask,     e.pm,         e.cyc);
                chk("in_stall",  32'(in_stall), 32'(e.ins),   e.cyc);
                chk("wdog_err",  32'(wdog_err), 32'(e.wd),    e.cyc);
`ifdef SCOREBOARD_PERF_EN
                chk("stall_cycles", stall_cycles_w, e.sc,     e.cyc);
`endif
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.allow = 1'b1;
        return s;
    endfunction

    function automatic stim_t ldw(input logic [4:0] wa);
        stim_t s;
        s = idle();
        s.valid = 1'b1; s.ld = 1'b1; s.we = 1'b1; s.wa = wa;
        return s;
    endfunction

    function automatic stim_t user(input logic [4:0] ra1);
        stim_t s;
        s = idle();
        s.valid = 1'b1; s.u1 = 1'b1; s.ra1 = ra1; s.we = 1'b1; s.wa = 5'd6;
        return s;
    endfunction

    function automatic stim_t with_done(input stim_t s0, input logic [4:0] dwa);
        stim_t s;
        s = s0;
        s.done = 1'b1; s.dwa = dwa;
        return s;
    endfunction

    initial begin
        stim_t s;
        cur = '0; cur.rst = 1'b1;
        cur_stall = 0; cur_issue = 0; cyc_n = 0;
        model_clear();

        s = idle(); s.rst = 1'b1;
        step(s); step(s);
        step(idle());

        // load r5 then dependent add; released by ld_done in the same cycle
        step(ldw(5'd5));
        step(user(5'd5)); step(user(5'd5)); step(user(5'd5));
        step(with_done(user(5'd5), 5'd5));
        step(idle()); step(idle());

        // r8 fills to 3, fourth load stalls on full counter, one ld_done frees it
        step(ldw(5'd8)); step(ldw(5'd8)); step(ldw(5'd8));
        step(ldw(5'd8)); step(ldw(5'd8));
        step(with_done(ldw(5'd8), 5'd8));
        step(with_done(idle(), 5'd8)); step(with_done(idle(), 5'd8)); step(with_done(idle(), 5'd8));
        step(idle());

        // simultaneous inc/dec on r9 keeps the count
        step(ldw(5'd9));
        step(with_done(ldw(5'd9), 5'd9));
        step(idle());
        step(with_done(idle(), 5'd9));
        step(idle());

        // ld_done to an idle register and a load to r0 change nothing
        step(with_done(idle(), 5'd3));
        step(ldw(5'd0));
        step(with_done(idle(), 5'd0));
        step(idle());

        // backpressure without hazard is not a stall
        s = ldw(5'd7); s.allow = 1'b0;
        step(s); step(s);
        step(idle());

        // randomized traffic over a small register window
        for (int k = 0; k < 800; k++) begin
            s = '0;
            s.valid = ($urandom_range(0, 9) < 8);
            s.u1    = $urandom_range(0, 1);
            s.u2    = $urandom_range(0, 1);
            s.ra1   = 5'($urandom_range(0, 5));
            s.ra2   = 5'($urandom_range(0, 5));
            s.we    = ($urandom_range(0, 3) != 0);
            s.ld    = ($urandom_range(0, 2) == 0);
            s.wa    = 5'($urandom_range(0, 5));
            s.allow = ($urandom_range(0, 4) != 0);
            s.done  = ($urandom_range(0, 9) < 4);
            s.dwa   = 5'($urandom_range(0, 5));
            if (k % 200 == 199) s.rst = 1'b1;
            step(s);
        end
        s = idle(); s.rst = 1'b1;
        step(s);
        step(idle());

        // watchdog: hazard on r4 held past MAX_STALL, sticky after it clears
        step(ldw(5'd4));
        for (int k = 0; k < MAX_STALL + 4; k++) step(user(5'd4));
        step(with_done(user(5'd4), 5'd4));
        step(idle()); step(idle());

        // asynchronous reset in the middle of a stall
        step(ldw(5'd4));
        step(user(5'd4)); step(user(5'd4)); step(user(5'd4));
        s = user(5'd4); s.rst = 1'b1;
        step(s);
        step(user(5'd4));
        step(idle());

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain leftover=%0d expected=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
